// File: rtl/fe_pkg.sv
// Shared definitions for the feature-extraction layer: FSM encoding, kernel geometry and widths.
package fe_pkg;

   localparam int unsigned FE_FILTER_SIZE = 5;
   localparam int unsigned FE_TAPS        = FE_FILTER_SIZE * FE_FILTER_SIZE;
   localparam int unsigned FE_COEF_W      = 16;
   localparam int unsigned FE_TAP_W       = 5;
   localparam int unsigned FE_FILT_W      = 6;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StDrain = 3'd2,
      StStart = 3'd3,
      StWait  = 3'd4,
      StNext  = 3'd5,
      StDone  = 3'd6
   } fe_state_e;

endpackage

// File: rtl/fe_coef_loader.sv
// Streams one filter's coefficients from weight memory into the datapath coefficient registers.
// Tap counter plus base accumulator form the address; writes trail reads by one cycle.
module fe_coef_loader
   import fe_pkg::*;
#(
   parameter int unsigned TAPS    = FE_TAPS,
   parameter int unsigned COEF_W  = FE_COEF_W,
   parameter int unsigned WADDR_W = 11
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                tile_start_in,
   input  logic                load_go_in,
   input  logic                base_adv_in,
   output logic                load_done_out,
   output logic                wmem_rd_en_out,
   output logic [WADDR_W-1:0]  wmem_addr_out,
   input  logic [COEF_W-1:0]   wmem_data_in,
   output logic                coef_wr_en_out,
   output logic [FE_TAP_W-1:0] coef_idx_out,
   output logic [COEF_W-1:0]   coef_data_out
);

   logic [FE_TAP_W-1:0] r_tap;
   logic [WADDR_W-1:0]  r_base;
   logic                r_wr_en;
   logic [FE_TAP_W-1:0] r_wr_idx;
   logic                w_last_tap;

   assign w_last_tap = (r_tap == FE_TAP_W'(TAPS - 1));

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_tap    <= '0;
         r_base   <= '0;
         r_wr_en  <= 1'b0;
         r_wr_idx <= '0;
      end else begin
         r_wr_en  <= load_go_in;
         r_wr_idx <= load_go_in ? r_tap : '0;
         if (tile_start_in) begin
            r_tap  <= '0;
            r_base <= '0;
         end else begin
            if (load_go_in) r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
            if (base_adv_in) r_base <= r_base + WADDR_W'(TAPS);
         end
      end
   end

   assign load_done_out  = load_go_in & w_last_tap;
   assign wmem_rd_en_out = load_go_in;
   assign wmem_addr_out  = load_go_in ? r_base + WADDR_W'(r_tap) : '0;
   assign coef_wr_en_out = r_wr_en;
   assign coef_idx_out   = r_wr_idx;
   // Memory output is already registered, so read data lines up with the delayed strobe.
   assign coef_data_out  = r_wr_en ? wmem_data_in : '0;

endmodule

// File: rtl/fe_filter_sequencer.sv
// Per-tile controller: loads each filter's coefficients, starts the datapath, forwards saves.
// Define FE_TIMEOUT_EN to add the WAIT-state watchdog and the sticky err_out port.
module fe_filter_sequencer
   import fe_pkg::*;
#(
   parameter int unsigned FILTER_SIZE    = FE_FILTER_SIZE,
   parameter int unsigned NUM_FILTERS    = 48,
   parameter int unsigned COEF_W         = FE_COEF_W,
   parameter int unsigned WADDR_W        = 11,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tile_valid_in,
   output logic                 tile_ready_out,
   output logic                 wmem_rd_en_out,
   output logic [WADDR_W-1:0]   wmem_addr_out,
   input  logic [COEF_W-1:0]    wmem_data_in,
   output logic                 coef_wr_en_out,
   output logic [FE_TAP_W-1:0]  coef_idx_out,
   output logic [COEF_W-1:0]    coef_data_out,
   output logic                 fe_start_out,
   input  logic                 fe_ready_in,
   input  logic                 fe_save_in,
   output logic                 out_valid_out,
   output logic [FE_FILT_W-1:0] filt_idx_out,
   output logic                 busy_out,
`ifdef FE_TIMEOUT_EN
   output logic                 err_out,
`endif
   output logic                 done_out
);

   localparam int unsigned TAPS = FILTER_SIZE * FILTER_SIZE;

   if ((1 << WADDR_W) < NUM_FILTERS * TAPS) begin : g_waddr_too_small
      $error("WADDR_W too small for NUM_FILTERS*TAPS");
   end
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be non-zero");
   end

   fe_state_e            r_state, w_state_next;
   logic [FE_FILT_W-1:0] r_filt;
   logic                 r_out_valid;
   logic                 w_last_filt, w_load_done, w_timeout;
   logic                 w_load_go, w_tile_start, w_base_adv;

   assign w_last_filt = (r_filt == FE_FILT_W'(NUM_FILTERS - 1));

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (tile_valid_in) w_state_next = StLoad;
         StLoad:  if (w_load_done) w_state_next = StDrain;
         StDrain: w_state_next = StStart;
         StStart: w_state_next = StWait;
         StWait: begin
            if (fe_ready_in)    w_state_next = StNext;
            else if (w_timeout) w_state_next = StIdle;
         end
         StNext:  w_state_next = w_last_filt ? StDone : StLoad;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      tile_ready_out = (r_state == StIdle);
      busy_out       = (r_state != StIdle);
      fe_start_out   = (r_state == StStart);
      done_out       = (r_state == StDone);
      w_load_go      = (r_state == StLoad);
      w_tile_start   = (r_state == StIdle) && tile_valid_in;
      w_base_adv     = (r_state == StNext) && !w_last_filt;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_filt      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (r_state == StWait) && fe_save_in;
         if (w_tile_start || (r_state == StDone) || w_timeout) r_filt <= '0;
         else if (w_base_adv)                                  r_filt <= r_filt + 1'b1;
      end
   end

   assign out_valid_out = r_out_valid;
   assign filt_idx_out  = r_filt;

`ifdef FE_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_err;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         r_wd_cnt <= ((r_state == StWait) && !fe_ready_in) ? r_wd_cnt + 1'b1 : '0;
         if (w_timeout) r_err <= 1'b1;
      end
   end

   // A ready arriving on the limit cycle takes priority over the timeout.
   assign w_timeout = (r_state == StWait) && !fe_ready_in &&
                      (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign err_out   = r_err;
`else
   assign w_timeout = 1'b0;
`endif

   fe_coef_loader #(
      .TAPS    (TAPS),
      .COEF_W  (COEF_W),
      .WADDR_W (WADDR_W)
   ) u_loader (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .tile_start_in  (w_tile_start),
      .load_go_in     (w_load_go),
      .base_adv_in    (w_base_adv),
      .load_done_out  (w_load_done),
      .wmem_rd_en_out (wmem_rd_en_out),
      .wmem_addr_out  (wmem_addr_out),
      .wmem_data_in   (wmem_data_in),
      .coef_wr_en_out (coef_wr_en_out),
      .coef_idx_out   (coef_idx_out),
      .coef_data_out  (coef_data_out)
   );

endmodule

// File: tb/tb_fe_filter_sequencer.sv
// Scoreboard bench for fe_filter_sequencer: ROM returns data = address, datapath model drives
// ready/save. Timeout scenarios run only when FE_TIMEOUT_EN is defined.
module tb_fe_filter_sequencer;

   localparam int NF      = 48;
   localparam int TAPS    = 25;
   localparam int COEF_W  = 16;
   localparam int WADDR_W = 11;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tile_valid, tile_ready;
   logic               wmem_rd_en;
   logic [WADDR_W-1:0] wmem_addr;
   logic [COEF_W-1:0]  wmem_data = '0;
   logic               coef_wr_en;
   logic [4:0]         coef_idx;
   logic [COEF_W-1:0]  coef_data;
   logic               fe_start, fe_ready, fe_save;
   logic               out_valid;
   logic [5:0]         filt_idx;
   logic               busy, done;
`ifdef FE_TIMEOUT_EN
   logic               err;
`endif

   always #5 clk = ~clk;

   fe_filter_sequencer #(
      .FILTER_SIZE    (5),
      .NUM_FILTERS    (NF),
      .COEF_W         (COEF_W),
      .WADDR_W        (WADDR_W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .tile_valid_in  (tile_valid),
      .tile_ready_out (tile_ready),
      .wmem_rd_en_out (wmem_rd_en),
      .wmem_addr_out  (wmem_addr),
      .wmem_data_in   (wmem_data),
      .coef_wr_en_out (coef_wr_en),
      .coef_idx_out   (coef_idx),
      .coef_data_out  (coef_data),
      .fe_start_out   (fe_start),
      .fe_ready_in    (fe_ready),
      .fe_save_in     (fe_save),
      .out_valid_out  (out_valid),
      .filt_idx_out   (filt_idx),
      .busy_out       (busy),
`ifdef FE_TIMEOUT_EN
      .err_out        (err),
`endif
      .done_out       (done)
   );

   // Weight ROM with registered read port: data = address.
   always @(posedge clk) if (wmem_rd_en) wmem_data <= COEF_W'(wmem_addr);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int exp_rd[$];
   int exp_wr_idx[$];
   int exp_wr_data[$];
   int exp_sv[$];

   task automatic push_exp(input int nfilt);
      for (int f = 0; f < nfilt; f++)
         for (int t = 0; t < TAPS; t++) begin
            exp_rd.push_back(f * TAPS + t);
            exp_wr_idx.push_back(t);
            exp_wr_data.push_back(f * TAPS + t);
         end
   endtask

   task automatic flush_exp();
      exp_rd.delete();
      exp_wr_idx.delete();
      exp_wr_data.delete();
      exp_sv.delete();
   endtask

   // Datapath model: 0 = ready 3 cycles after start, 1 = ready held, 2 = never, 3 = ready at 16.
   int dp_mode = 0;
   bit save_en = 0;
   int n_starts = 0;
   int since = 0;
   bit armed = 0;

   initial begin
      fe_ready = 1'b0;
      fe_save  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fe_save = 1'b0;
         if (!rst_n) begin
            armed    = 0;
            since    = 0;
            fe_ready = 1'b0;
         end else begin
            if (fe_start) begin
               armed = 1;
               since = 0;
               n_starts++;
            end else if (armed) begin
               since++;
            end
            case (dp_mode)
               0:       fe_ready = armed && since == 3;
               1:       fe_ready = 1'b1;
               3:       fe_ready = armed && since == 16;
               default: fe_ready = 1'b0;
            endcase
            if (save_en) begin
               if (armed && n_starts == 6 && (since == 1 || since == 2)) begin
                  fe_save = 1'b1;
                  exp_sv.push_back(5);
               end
               if (armed && n_starts == 10 && since == 3) begin
                  fe_save = 1'b1;
                  exp_sv.push_back(9);
               end
               // Saves outside WAIT must be dropped: one mid-LOAD, one in a START cycle.
               if (wmem_rd_en && wmem_addr == WADDR_W'(5 * TAPS + 10)) fe_save = 1'b1;
               if (fe_start && n_starts == 8) fe_save = 1'b1;
            end
            if (fe_ready && armed) armed = 0;
         end
      end
   end

   int n_done = 0;
   int n_start_mon = 0;
   int n_outv = 0;
   bit done_q = 0;
   bit prev_rd = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         done_q  = 0;
         prev_rd = 0;
      end else begin
         if (wmem_rd_en) begin
            if (exp_rd.size() == 0) check_eq("rd_unexpected", 32'(wmem_addr), 32'hFFFF_FFFF);
            else                    check_eq("rd_addr", 32'(wmem_addr), exp_rd.pop_front());
         end
         if (coef_wr_en) begin
            check_eq("wr_one_after_rd", 32'(prev_rd), 1);
            if (exp_wr_idx.size() == 0) begin
               check_eq("wr_unexpected", 32'(coef_idx), 32'hFFFF_FFFF);
            end else begin
               check_eq("wr_idx", 32'(coef_idx), exp_wr_idx.pop_front());
               check_eq("wr_data", 32'(coef_data), exp_wr_data.pop_front());
            end
         end
         if (out_valid) begin
            n_outv++;
            if (exp_sv.size() == 0) check_eq("outv_unexpected", 32'(filt_idx), 32'hFFFF_FFFF);
            else                    check_eq("outv_filt", 32'(filt_idx), exp_sv.pop_front());
         end
         if (fe_start) n_start_mon++;
         if (done_q) check_eq("ready_after_done", 32'(tile_ready), 1);
         if (done) n_done++;
         done_q  = done;
         prev_rd = wmem_rd_en;
      end
   end

   task automatic start_tile();
      @(posedge clk);
      #1 tile_valid = 1'b1;
      @(posedge clk);
      #1 tile_valid = 1'b0;
   endtask

   task automatic wait_done(input int max, output time t_done);
      int i;
      t_done = 0;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (done) break;
      end
      t_done = $time;
      check_eq("done_in_time", 32'(i < max), 1);
      @(negedge clk);
   endtask

   task automatic clear_counts();
      n_done      = 0;
      n_start_mon = 0;
      n_outv      = 0;
      n_starts    = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   time t0, t1;

   initial begin
      int i;
      rst_n      = 1'b0;
      tile_valid = 1'b0;
      #2;
      check_eq("rst_tile_ready", 32'(tile_ready), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_outs_zero", 32'(|{wmem_rd_en, wmem_addr, coef_wr_en, coef_idx, coef_data,
                                      fe_start, out_valid, filt_idx, done}), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Tile 1: ready 3 cycles after start, save forwarding, stray tile_valid while busy.
      dp_mode = 0;
      save_en = 1;
      clear_counts();
      push_exp(NF);
      start_tile();
      check_eq("busy_after_accept", 32'(busy), 1);
      repeat (200) @(posedge clk);
      #1 tile_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 tile_valid = 1'b0;
      wait_done(3000, t1);
      check_eq("t1_done_count", 32'(n_done), 1);
      check_eq("t1_start_count", 32'(n_start_mon), NF);
      check_eq("t1_rd_left", 32'(exp_rd.size()), 0);
      check_eq("t1_wr_left", 32'(exp_wr_idx.size()), 0);
      check_eq("t1_outv_count", 32'(n_outv), 3);
      check_eq("t1_sv_left", 32'(exp_sv.size()), 0);
      check_eq("t1_idle_filt", 32'(filt_idx), 0);

      // Tile 2: ready held high, 29 cycles per filter.
      dp_mode = 1;
      save_en = 0;
      clear_counts();
      push_exp(NF);
      start_tile();
      t0 = 0;
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wmem_rd_en) begin
            t0 = $time;
            break;
         end
      end
      check_eq("t2_load_seen", 32'(i < 10), 1);
      wait_done(3000, t1);
      check_eq("t2_latency", 32'((t1 - t0) / 10), NF * 29);
      check_eq("t2_done_count", 32'(n_done), 1);
      check_eq("t2_rd_left", 32'(exp_rd.size()), 0);

      // Tile 3: async reset during filter 10 load, then a fresh tile from address 0.
      dp_mode = 0;
      clear_counts();
      push_exp(NF);
      start_tile();
      for (i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (n_starts == 10 && wmem_rd_en) break;
      end
      check_eq("t3_reached_f10", 32'(i < 2000), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t3_async_outs_zero", 32'(|{wmem_rd_en, wmem_addr, coef_wr_en, coef_idx,
                                           coef_data, fe_start, out_valid, filt_idx, done,
                                           busy}), 0);
      check_eq("t3_async_ready", 32'(tile_ready), 1);
      flush_exp();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check_eq("t3_ready_after_rel", 32'(tile_ready), 1);
      check_eq("t3_no_done", 32'(n_done), 0);
      clear_counts();
      push_exp(NF);
      start_tile();
      wait_done(3000, t1);
      check_eq("t4_done_count", 32'(n_done), 1);
      check_eq("t4_rd_left", 32'(exp_rd.size()), 0);

`ifdef FE_TIMEOUT_EN
      // Watchdog: never ready -> error after 16 WAIT cycles, no done.
      dp_mode = 2;
      clear_counts();
      push_exp(1);
      start_tile();
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (err) break;
      end
      check_eq("to_err_set", 32'(err), 1);
      check_eq("to_idle", 32'(tile_ready), 1);
      repeat (3) @(negedge clk);
      check_eq("to_no_done", 32'(n_done), 0);
      check_eq("to_err_sticky", 32'(err), 1);
      check_eq("to_rd_left", 32'(exp_rd.size()), 0);
      flush_exp();
      do_reset();
      // Ready on the 16th WAIT cycle beats the watchdog.
      dp_mode = 3;
      clear_counts();
      push_exp(NF);
      start_tile();
      wait_done(4000, t1);
      check_eq("to_ready_wins_err", 32'(err), 0);
      check_eq("to_ready_wins_done", 32'(n_done), 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
